fb_draw_arbiter: RTL and testbench

Sequencing and arbitration controller for the double-buffered framebuffer write port. It clears the back buffer at the start of each frame, then shares the single write port between two drawing requesters with round-robin arbitration. It holds completed frames until the display's `new_frame` pulse and then swaps the display and back buffers. It sits between the drawing engines and `framebuffer_module`; it consumes `new_frame` from `output_module`.

---
 rtl/fb_draw_arbiter_if.sv | 33 +++
 rtl/fb_draw_arbiter.sv | 134 +++++++++++++
 tb/tb_fb_draw_arbiter.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fb_draw_arbiter_if.sv
// Bus bundle between the drawing engines / output module and the framebuffer write arbiter.
// The master modport is the environment side; the slave modport is the arbiter.
interface fb_draw_arbiter_if #(
    parameter int X_W = 10,
    parameter int Y_W = 9
);
    logic               new_frame;
    logic               draw_done;
    logic [2:0]         clear_color;
    logic [1:0]         req_valid;
    logic [2*X_W-1:0]   req_x;
    logic [2*Y_W-1:0]   req_y;
    logic [5:0]         req_color;
    logic [1:0]         req_ready;
    logic               wr_en;
    logic [X_W-1:0]     wr_x;
    logic [Y_W-1:0]     wr_y;
    logic [2:0]         wr_color;
    logic               wr_buf;
    logic               disp_buf;
    logic               swapped;
    logic [7:0]         drop_cnt;

    modport master (
        output new_frame, draw_done, clear_color, req_valid, req_x, req_y, req_color,
        input  req_ready, wr_en, wr_x, wr_y, wr_color, wr_buf, disp_buf, swapped, drop_cnt
    );

    modport slave (
        input  new_frame, draw_done, clear_color, req_valid, req_x, req_y, req_color,
        output req_ready, wr_en, wr_x, wr_y, wr_color, wr_buf, disp_buf, swapped, drop_cnt
    );
endinterface

// File: rtl/fb_draw_arbiter.sv
// Double-buffered framebuffer write-port controller: clears the back buffer each frame,
// round-robins two drawing requesters onto the write port, and swaps buffers on new_frame.
module fb_draw_arbiter #(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 9
) (
    input logic             Clk,
    input logic             Reset,
    fb_draw_arbiter_if.slave bus
);
    localparam logic [1:0] S_CLEAR = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
    localparam logic [X_W:0]   W_LIM  = (X_W+1)'(SCREEN_W);
    localparam logic [Y_W:0]   H_LIM  = (Y_W+1)'(SCREEN_H);

    logic [1:0]     r_state;
    logic           r_disp;
    logic           r_rr;
    logic [X_W-1:0] r_cx;
    logic [Y_W-1:0] r_cy;
    logic [2:0]     r_ccolor;
    logic           r_wr_en;
    logic [X_W-1:0] r_wr_x;
    logic [Y_W-1:0] r_wr_y;
    logic [2:0]     r_wr_color;
    logic           r_swapped;
    logic [7:0]     r_drop;

    logic [1:0]     w_grant;
    logic [X_W-1:0] w_x;
    logic [Y_W-1:0] w_y;
    logic [2:0]     w_color;
    logic           w_in_range;
    logic           w_clr_last;
    logic [2:0]     w_clr_color;

    always_comb begin
        w_grant = '0;
        if (r_state == S_DRAW) begin
            w_grant[0] = bus.req_valid[0] && (!r_rr || !bus.req_valid[1]);
            w_grant[1] = bus.req_valid[1] && ( r_rr || !bus.req_valid[0]);
        end
    end

    always_comb begin
        w_x        = w_grant[1] ? bus.req_x[2*X_W-1:X_W] : bus.req_x[X_W-1:0];
        w_y        = w_grant[1] ? bus.req_y[2*Y_W-1:Y_W] : bus.req_y[Y_W-1:0];
        w_color    = w_grant[1] ? bus.req_color[5:3]     : bus.req_color[2:0];
        w_in_range = ({1'b0, w_x} < W_LIM) && ({1'b0, w_y} < H_LIM);
    end

    // The first clear pixel takes clear_color live and latches it for the rest of the frame.
    always_comb begin
        w_clr_last  = (r_cx == X_LAST) && (r_cy == Y_LAST);
        w_clr_color = (r_cx == '0 && r_cy == '0) ? bus.clear_color : r_ccolor;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_state    <= S_CLEAR;
            r_disp     <= 1'b0;
            r_rr       <= 1'b0;
            r_cx       <= '0;
            r_cy       <= '0;
            r_ccolor   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_x     <= '0;
            r_wr_y     <= '0;
            r_wr_color <= '0;
            r_swapped  <= 1'b0;
            r_drop     <= '0;
        end else begin
            r_wr_en   <= 1'b0;
            r_swapped <= 1'b0;
            case (r_state)
                S_CLEAR: begin
                    r_wr_en    <= 1'b1;
                    r_wr_x     <= r_cx;
                    r_wr_y     <= r_cy;
                    r_wr_color <= w_clr_color;
                    r_ccolor   <= w_clr_color;
                    if (w_clr_last) begin
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_state <= S_DRAW;
                    end else if (r_cx == X_LAST) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 1'b1;
                    end else begin
                        r_cx <= r_cx + 1'b1;
                    end
                end
                S_DRAW: begin
                    if (|w_grant) begin
                        r_rr <= w_grant[0];
                        if (w_in_range) begin
                            r_wr_en    <= 1'b1;
                            r_wr_x     <= w_x;
                            r_wr_y     <= w_y;
                            r_wr_color <= w_color;
                        end else if (r_drop != 8'hFF) begin
                            r_drop <= r_drop + 8'd1;
                        end
                    end
                    if (bus.draw_done) r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bus.new_frame) begin
                        r_disp    <= ~r_disp;
                        r_swapped <= 1'b1;
                        r_state   <= S_CLEAR;
                    end
                end
                default: r_state <= S_CLEAR;
            endcase
        end
    end

    assign bus.req_ready = w_grant;
    assign bus.wr_en     = r_wr_en;
    assign bus.wr_x      = r_wr_x;
    assign bus.wr_y      = r_wr_y;
    assign bus.wr_color  = r_wr_color;
    assign bus.wr_buf    = ~r_disp;
    assign bus.disp_buf  = r_disp;
    assign bus.swapped   = r_swapped;
    assign bus.drop_cnt  = r_drop;
endmodule

// File: tb/tb_fb_draw_arbiter.sv
// Directed self-checking bench for fb_draw_arbiter on a 4x3 screen.
module tb_fb_draw_arbiter;
    logic Clk;
    logic Reset;
    int   n_cmp;
    int   n_err;

    fb_draw_arbiter_if #(.X_W(10), .Y_W(9)) bus ();

    fb_draw_arbiter #(.SCREEN_W(4), .SCREEN_H(3), .X_W(10), .Y_W(9)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic test_reset();
        logic [22:0] exp;
        Reset = 1'b0;
        bus.clear_color = 3'd5;
        bus.req_valid = 2'b00;
        tick();
        tick();
        n_cmp++;
        if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color} !== 23'd0) begin
            n_err++; $display("FAIL reset_wr: got %0h expected 0", {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color});
        end
        n_cmp++;
        if ({bus.disp_buf, bus.wr_buf, bus.swapped, bus.drop_cnt} !== {1'b0, 1'b1, 1'b0, 8'd0}) begin
            n_err++; $display("FAIL reset_bufs: got %0h expected %0h", {bus.disp_buf, bus.wr_buf, bus.swapped, bus.drop_cnt}, {1'b0, 1'b1, 1'b0, 8'd0});
        end
        Reset = 1'b1;
        bus.req_valid = 2'b11;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = {1'b1, 10'(i % 4), 9'(i / 4), 3'd5};
            n_cmp++;
            if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color} !== exp) begin
                n_err++; $display("FAIL clear_px%0d: got %0h expected %0h", i, {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color}, exp);
            end
            n_cmp++;
            if (bus.wr_buf !== 1'b1) begin
                n_err++; $display("FAIL clear_wrbuf%0d: got %0b expected 1", i, bus.wr_buf);
            end
            n_cmp++;
            if (bus.req_ready !== ((i == 11) ? 2'b01 : 2'b00)) begin
                n_err++; $display("FAIL clear_ready%0d: got %0b expected %0b", i, bus.req_ready, (i == 11) ? 2'b01 : 2'b00);
            end
        end
        bus.req_valid = 2'b00;
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
            n_err++; $display("FAIL clear_end: wr_en got %0b expected 0", bus.wr_en);
        end
    endtask

    task automatic test_contention();
        logic [22:0] exp;
        logic [1:0]  exp_rdy;
        int g;
        g = 0;
        bus.req_x = {10'd2, 10'd1};
        bus.req_y = {9'd2, 9'd1};
        bus.req_color = {3'd3, 3'd2};
        bus.req_valid = 2'b11;
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b01) begin
            n_err++; $display("FAIL cont_first: got %0b expected 01", bus.req_ready);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            exp = (g == 0) ? {1'b1, 10'd1, 9'd1, 3'd2} : {1'b1, 10'd2, 9'd2, 3'd3};
            n_cmp++;
            if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color} !== exp) begin
                n_err++; $display("FAIL cont_wr%0d: got %0h expected %0h", i, {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color}, exp);
            end
            g = 1 - g;
            exp_rdy = (g == 1) ? 2'b10 : 2'b01;
            n_cmp++;
            if (bus.req_ready !== exp_rdy) begin
                n_err++; $display("FAIL cont_rdy%0d: got %0b expected %0b", i, bus.req_ready, exp_rdy);
            end
        end
        bus.req_valid = 2'b00;
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
            n_err++; $display("FAIL cont_idle: wr_en got %0b expected 0", bus.wr_en);
        end
    endtask

    task automatic test_single();
        bus.req_x = {10'd3, 10'd1};
        bus.req_y = {9'd2, 9'd1};
        bus.req_color = {3'd7, 3'd2};
        bus.req_valid = 2'b10;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== 2'b10) begin
                n_err++; $display("FAIL single_rdy%0d: got %0b expected 10", i, bus.req_ready);
            end
            tick();
            n_cmp++;
            if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color} !== {1'b1, 10'd3, 9'd2, 3'd7}) begin
                n_err++; $display("FAIL single_wr%0d: got %0h expected %0h", i, {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color}, {1'b1, 10'd3, 9'd2, 3'd7});
            end
        end
        bus.req_valid = 2'b00;
        tick();
    endtask

    task automatic test_drop();
        bus.req_x = {10'd4, 10'd1};
        bus.req_y = {9'd0, 9'd1};
        bus.req_valid = 2'b10;
        #1;
        n_cmp++;
        if (bus.req_ready !== 2'b10) begin
            n_err++; $display("FAIL drop_rdy: got %0b expected 10", bus.req_ready);
        end
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
            n_err++; $display("FAIL drop_x_wr: wr_en got %0b expected 0", bus.wr_en);
        end
        bus.req_x = {10'd0, 10'd1};
        bus.req_y = {9'd3, 9'd1};
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
            n_err++; $display("FAIL drop_y_wr: wr_en got %0b expected 0", bus.wr_en);
        end
        bus.req_valid = 2'b00;
        tick();
        n_cmp++;
        if (bus.drop_cnt !== 8'd2) begin
            n_err++; $display("FAIL drop_cnt2: got %0d expected 2", bus.drop_cnt);
        end
        bus.req_x = {10'd4, 10'd1};
        bus.req_y = {9'd1, 9'd1};
        bus.req_valid = 2'b10;
        for (int i = 0; i < 300; i++) tick();
        bus.req_valid = 2'b00;
        tick();
        n_cmp++;
        if ({bus.wr_en, bus.drop_cnt} !== {1'b0, 8'd255}) begin
            n_err++; $display("FAIL drop_sat: got %0h expected %0h", {bus.wr_en, bus.drop_cnt}, {1'b0, 8'd255});
        end
    endtask

    task automatic test_swap();
        logic [22:0] exp;
        bus.req_x = {10'd2, 10'd1};
        bus.req_y = {9'd2, 9'd1};
        bus.req_color = {3'd3, 3'd2};
        bus.clear_color = 3'd3;
        bus.req_valid = 2'b01;
        bus.draw_done = 1'b1;
        bus.new_frame = 1'b1;
        tick();
        bus.draw_done = 1'b0;
        bus.new_frame = 1'b0;
        n_cmp++;
        if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color} !== {1'b1, 10'd1, 9'd1, 3'd2}) begin
            n_err++; $display("FAIL swap_lastgrant: got %0h expected %0h", {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color}, {1'b1, 10'd1, 9'd1, 3'd2});
        end
        n_cmp++;
        if ({bus.swapped, bus.disp_buf} !== 2'b00) begin
            n_err++; $display("FAIL swap_same_cycle: swapped/disp got %0b expected 00", {bus.swapped, bus.disp_buf});
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (bus.req_ready !== 2'b00) begin
                n_err++; $display("FAIL wait_rdy%0d: got %0b expected 00", i, bus.req_ready);
            end
            tick();
            n_cmp++;
            if ({bus.wr_en, bus.swapped, bus.disp_buf} !== 3'b000) begin
                n_err++; $display("FAIL wait_hold%0d: got %0b expected 000", i, {bus.wr_en, bus.swapped, bus.disp_buf});
            end
        end
        bus.new_frame = 1'b1;
        tick();
        bus.new_frame = 1'b0;
        n_cmp++;
        if ({bus.swapped, bus.disp_buf, bus.wr_buf, bus.wr_en} !== 4'b1100) begin
            n_err++; $display("FAIL swap_pulse: got %0b expected 1100", {bus.swapped, bus.disp_buf, bus.wr_buf, bus.wr_en});
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = {1'b1, 10'(i % 4), 9'(i / 4), 3'd3};
            n_cmp++;
            if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color} !== exp) begin
                n_err++; $display("FAIL swap_clear%0d: got %0h expected %0h", i, {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color}, exp);
            end
            n_cmp++;
            if ({bus.swapped, bus.wr_buf} !== 2'b00) begin
                n_err++; $display("FAIL swap_clrbuf%0d: got %0b expected 00", i, {bus.swapped, bus.wr_buf});
            end
            n_cmp++;
            if (bus.req_ready !== ((i == 11) ? 2'b01 : 2'b00)) begin
                n_err++; $display("FAIL swap_stall%0d: got %0b expected %0b", i, bus.req_ready, (i == 11) ? 2'b01 : 2'b00);
            end
        end
        bus.req_valid = 2'b00;
        tick();
    endtask

    task automatic test_midreset();
        logic [22:0] exp;
        Reset = 1'b0;
        tick();
        n_cmp++;
        if ({bus.wr_en, bus.disp_buf, bus.wr_buf, bus.drop_cnt} !== {1'b0, 1'b0, 1'b1, 8'd0}) begin
            n_err++; $display("FAIL rst_from_draw: got %0h expected %0h", {bus.wr_en, bus.disp_buf, bus.wr_buf, bus.drop_cnt}, {1'b0, 1'b0, 1'b1, 8'd0});
        end
        Reset = 1'b1;
        bus.clear_color = 3'd6;
        for (int i = 0; i < 8; i++) begin
            tick();
            exp = {1'b1, 10'(i % 4), 9'(i / 4), 3'd6};
            n_cmp++;
            if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color} !== exp) begin
                n_err++; $display("FAIL mid_pre%0d: got %0h expected %0h", i, {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color}, exp);
            end
        end
        Reset = 1'b0;
        bus.clear_color = 3'd1;
        for (int i = 0; i < 2; i++) begin
            tick();
            n_cmp++;
            if ({bus.wr_en, bus.disp_buf} !== 2'b00) begin
                n_err++; $display("FAIL mid_rst%0d: wr_en/disp got %0b expected 00", i, {bus.wr_en, bus.disp_buf});
            end
        end
        Reset = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            exp = {1'b1, 10'(i % 4), 9'(i / 4), 3'd1};
            n_cmp++;
            if ({bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color} !== exp) begin
                n_err++; $display("FAIL mid_restart%0d: got %0h expected %0h", i, {bus.wr_en, bus.wr_x, bus.wr_y, bus.wr_color}, exp);
            end
        end
        tick();
        n_cmp++;
        if (bus.wr_en !== 1'b0) begin
            n_err++; $display("FAIL mid_done: wr_en got %0b expected 0", bus.wr_en);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        Reset = 1'b0;
        bus.new_frame = 1'b0;
        bus.draw_done = 1'b0;
        bus.clear_color = 3'd0;
        bus.req_valid = 2'b00;
        bus.req_x = '0;
        bus.req_y = '0;
        bus.req_color = '0;
        test_reset();
        test_contention();
        test_single();
        test_drop();
        test_swap();
        test_midreset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
